// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between instruction fetch and data access.
// Optional watchdog enabled by defining MEMARB_TIMEOUT_EN (terminates an access after TIMEOUT busy cycles).
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          d_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
   state_t state;

   logic busy;
   logic expired;
   assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef MEMARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] wait_cnt;

   // Counter is zero whenever a new access is granted out of IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (!busy)
         wait_cnt <= '0;
      else if (!mem_ack)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign expired = busy && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign expired        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         if_err    <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         if_err   <= 1'b0;
         d_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (d_req) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (if_req) begin
                  state    <= BUSY_I;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (state == BUSY_I) begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end else begin
                     if (!mem_we)
                        d_rdata <= mem_rdata;
                     d_ready <= 1'b1;
                  end
               end else if (expired) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (state == BUSY_I) begin
                     if_rdata <= '0;
                     if_ready <= 1'b1;
                     if_err   <= 1'b1;
                  end else begin
                     d_rdata <= '0;
                     d_ready <= 1'b1;
                     d_err   <= 1'b1;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
